// File: rtl/game_pkg.sv
// Shared types and constants for the two-player LED memory game round sequencer.
package game_pkg;

    localparam int TIMER_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_TGT,
        SHOW,
        INPUT,
        CHECK,
        RESULT,
        OVER
    } state_t;

    // 7-segment patterns, segments active-low.
    localparam logic [31:0] FLAG_CORRECT = 32'hC2A3_A3A1;
    localparam logic [31:0] FLAG_WRONG   = 32'hC7C0_9286;
    localparam logic [31:0] FLAG_BLANK   = 32'hFFFF_FFFF;

    // Game result encodings.
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // One life lost, never wrapping below zero.
    function automatic logic [3:0] lives_dec(input logic [3:0] lives);
        return (lives == 4'd0) ? 4'd0 : lives - 4'd1;
    endfunction

    // Winner from the final life counts; the player still holding lives wins.
    function automatic logic [1:0] judge(input logic [3:0] lives_a, input logic [3:0] lives_b);
        if (lives_a == 4'd0 && lives_b == 4'd0) return WIN_DRAW;
        if (lives_b == 4'd0)                    return WIN_A;
        if (lives_a == 4'd0)                    return WIN_B;
        return WIN_NONE;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter shared by the show, input and result phases.
// Loading N-1 makes done pulse on the N-th cycle after the load.
module phase_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;
    logic         running;

    // Count down while armed; a load always wins over the expiry of the previous phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= load_val;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) running <= 1'b0;
            else             count   <= count - 1'b1;
        end
    end

    assign done = running && (count == '0);

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: fetches a target, shows it, collects both guesses,
// scores them, tracks lives and declares the winner.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES   = 25000000,
    parameter int unsigned INPUT_CYCLES  = 250000000,
    parameter int unsigned RESULT_CYCLES = 50000000,
    parameter int unsigned LIVES_INIT    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enter,
    input  logic [4:0]  sw_A,
    input  logic [4:0]  sw_B,
    output logic        gen_step,
    input  logic        tgt_valid,
    input  logic [9:0]  tgt,
    output logic [9:0]  led_out,
    output logic [31:0] flag,
    output logic [3:0]  seg_A,
    output logic [3:0]  seg_B,
    output logic [7:0]  round,
    output logic        busy,
    output logic [1:0]  winner
);

    if (SHOW_CYCLES < 1 || INPUT_CYCLES < 1 || RESULT_CYCLES < 1) begin : g_bad_cycles
        $error("game_round_ctrl: SHOW/INPUT/RESULT_CYCLES must all be at least 1");
    end
    if (LIVES_INIT < 1 || LIVES_INIT > 15) begin : g_bad_lives
        $error("game_round_ctrl: LIVES_INIT must be between 1 and 15");
    end

    localparam logic [TIMER_W-1:0] SHOW_LOAD   = TIMER_W'(SHOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] INPUT_LOAD  = TIMER_W'(INPUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RESULT_LOAD = TIMER_W'(RESULT_CYCLES - 1);
    localparam logic [3:0]         LIVES_RST   = 4'(LIVES_INIT);

    state_t               state, next_state;
    logic                 enter_q, enter_rise;
    logic [9:0]           tgt_r;
    logic [4:0]           guess_a, guess_b;
    logic                 timeout_q;
    logic                 ok_a, ok_b;
    logic                 timer_load, timer_done;
    logic [TIMER_W-1:0]   timer_val;

    assign enter_rise = enter & ~enter_q;
    assign ok_a       = !timeout_q && (guess_a == tgt_r[9:5]);
    assign ok_b       = !timeout_q && (guess_b == tgt_r[4:0]);

    phase_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    // State register.
    // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state decode and phase timer loads.
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            IDLE:     if (enter_rise) next_state = ARM;
            ARM:      next_state = WAIT_TGT;
            WAIT_TGT: if (tgt_valid) begin
                          next_state = SHOW;
                          timer_load = 1'b1;
                          timer_val  = SHOW_LOAD;
                      end
            SHOW:     if (timer_done) begin
                          next_state = INPUT;
                          timer_load = 1'b1;
                          timer_val  = INPUT_LOAD;
                      end
            INPUT:    if (enter_rise || timer_done) next_state = CHECK;
            CHECK:    begin
                          next_state = RESULT;
                          timer_load = 1'b1;
                          timer_val  = RESULT_LOAD;
                      end
            RESULT:   if (timer_done)
                          next_state = (seg_A == 4'd0 || seg_B == 4'd0) ? OVER : ARM;
            OVER:     if (enter_rise) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Registered outputs, captured target/guesses and the lives/round bookkeeping.
    // NOTE: the captured target and guesses are reset too, so a CHECK can never compare against X.
    always_ff @(posedge clk) begin
        if (rst) begin
            enter_q   <= 1'b0;
            gen_step  <= 1'b0;
            busy      <= 1'b0;
            led_out   <= '0;
            flag      <= FLAG_BLANK;
            seg_A     <= LIVES_RST;
            seg_B     <= LIVES_RST;
            round     <= '0;
            winner    <= WIN_NONE;
            tgt_r     <= '0;
            guess_a   <= '0;
            guess_b   <= '0;
            timeout_q <= 1'b0;
        end else begin
            enter_q  <= enter;
            // gen_step is the registered image of ARM, so it trails the ARM cycle by one clock.
            gen_step <= (state == ARM);
            busy     <= (next_state != IDLE) && (next_state != OVER);
            case (state)
                WAIT_TGT: if (tgt_valid) begin
                              tgt_r   <= tgt;
                              led_out <= tgt;
                          end
                SHOW:     if (timer_done) led_out <= '0;
                INPUT:    if (enter_rise) begin
                              guess_a   <= sw_A;
                              guess_b   <= sw_B;
                              timeout_q <= 1'b0;
                          end else if (timer_done) begin
                              timeout_q <= 1'b1;
                          end
                CHECK:    begin
                              if (!ok_a) seg_A <= lives_dec(seg_A);
                              if (!ok_b) seg_B <= lives_dec(seg_B);
                              flag <= (ok_a && ok_b) ? FLAG_CORRECT : FLAG_WRONG;
                              if (round != 8'hFF) round <= round + 8'd1;
                          end
                RESULT:   if (timer_done) begin
                              if (seg_A == 4'd0 || seg_B == 4'd0) winner <= judge(seg_A, seg_B);
                              else                                flag   <= FLAG_BLANK;
                          end
                OVER:     if (enter_rise) begin
                              seg_A  <= LIVES_RST;
                              seg_B  <= LIVES_RST;
                              round  <= '0;
                              winner <= WIN_NONE;
                              flag   <= FLAG_BLANK;
                          end
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Self-checking bench for game_round_ctrl: constant round table, model-driven
// random games, round-counter saturation and reset in the middle of a round.
module tb_game_round_ctrl;

    localparam int SHOW_C   = 4;
    localparam int INPUT_C  = 10;
    localparam int RESULT_C = 3;
    localparam int LIVES    = 3;

    localparam logic [31:0] F_OK    = 32'hC2A3A3A1;
    localparam logic [31:0] F_BAD   = 32'hC7C09286;
    localparam logic [31:0] F_BLANK = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enter = 1'b0;
    logic [4:0]  sw_A = '0;
    logic [4:0]  sw_B = '0;
    logic        gen_step;
    logic        tgt_valid = 1'b0;
    logic [9:0]  tgt = '0;
    logic [9:0]  led_out;
    logic [31:0] flag;
    logic [3:0]  seg_A, seg_B;
    logic [7:0]  round;
    logic        busy;
    logic [1:0]  winner;

    int n_checks = 0;
    int n_errors = 0;

    // Reference game state.
    int m_lives_a, m_lives_b, m_round;
    bit m_over;

    typedef struct {
        logic [9:0]  tgt;
        logic [4:0]  a;
        logic [4:0]  b;
        int          enter_at;   // INPUT cycle of the enter press, -1 for timeout
        bit          show_press;
        logic [31:0] flag;
        logic [3:0]  lives_a;
        logic [3:0]  lives_b;
        logic [7:0]  rnd;
        bit          over;
        logic [1:0]  win;
    } vec_t;

    vec_t vecs[8];

    game_round_ctrl #(
        .SHOW_CYCLES   (SHOW_C),
        .INPUT_CYCLES  (INPUT_C),
        .RESULT_CYCLES (RESULT_C),
        .LIVES_INIT    (LIVES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enter     (enter),
        .sw_A      (sw_A),
        .sw_B      (sw_B),
        .gen_step  (gen_step),
        .tgt_valid (tgt_valid),
        .tgt       (tgt),
        .led_out   (led_out),
        .flag      (flag),
        .seg_A     (seg_A),
        .seg_B     (seg_B),
        .round     (round),
        .busy      (busy),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // From IDLE: press enter and confirm gen_step arrives on the second cycle.
    task automatic start_game();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        check("gen_lat_c1", 32'(gen_step), 32'd0);
        tick();
        check("gen_lat_c2", 32'(gen_step), 32'd1);
    endtask

    // From OVER: press enter and confirm the game is back to its starting state.
    task automatic end_game();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        check("over_exit_busy",   32'(busy),   32'd0);
        check("over_exit_seg_A",  32'(seg_A),  32'(LIVES));
        check("over_exit_seg_B",  32'(seg_B),  32'(LIVES));
        check("over_exit_round",  32'(round),  32'd0);
        check("over_exit_winner", 32'(winner), 32'd0);
        check("over_exit_flag",   flag,        F_BLANK);
        tick();
        check("idle_no_gen", 32'(gen_step), 32'd0);
    endtask

    // One full round, entered anywhere between ARM and the gen_step cycle.
    task automatic play_round(input logic [9:0] t, input logic [4:0] a, input logic [4:0] b,
                              input int enter_at, input int vdelay, input bit show_press,
                              input logic [31:0] exp_flag, input logic [3:0] exp_la,
                              input logic [3:0] exp_lb, input logic [7:0] exp_rnd,
                              input bit exp_over, input logic [1:0] exp_win);
        int n;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (gen_step) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("gen_step_seen", 32'(seen), 32'd1);
        tgt = ~t;
        for (int i = 0; i < vdelay; i++) begin
            tick();
            if (i == 0) check("gen_step_width", 32'(gen_step), 32'd0);
        end
        tgt = t;
        tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        tgt = ~t;
        if (vdelay == 0) check("gen_step_width", 32'(gen_step), 32'd0);

        n = 0;
        while (n < 20 && led_out == t) begin
            if (show_press) enter = (n == 1);
            n++;
            tick();
        end
        enter = 1'b0;
        check("show_len", 32'(n), 32'(SHOW_C));
        check("led_cleared", 32'(led_out), 32'd0);

        sw_A = (enter_at < 0) ? a : ~a;
        sw_B = (enter_at < 0) ? b : ~b;
        if (show_press) begin
            tgt_valid = 1'b1;
            tgt = ~t;
        end
        for (int i = 0; i < INPUT_C; i++) begin
            if (i == enter_at) begin
                sw_A = a;
                sw_B = b;
                enter = 1'b1;
            end
            tick();
            tgt_valid = 1'b0;
            enter = 1'b0;
            if (i == enter_at) break;
        end
        sw_A = ~a;
        sw_B = ~b;
        check("led_input_phase", 32'(led_out), 32'd0);
        tick();
        check("seg_A", 32'(seg_A), 32'(exp_la));
        check("seg_B", 32'(seg_B), 32'(exp_lb));
        check("round", 32'(round), 32'(exp_rnd));

        n = 0;
        while (n < 20 && flag == exp_flag && busy) begin
            n++;
            tick();
        end
        check("result_len", 32'(n), 32'(RESULT_C));
        if (exp_over) begin
            check("over_busy",   32'(busy),   32'd0);
            check("over_winner", 32'(winner), 32'(exp_win));
            check("over_flag",   flag,        F_BAD);
        end else begin
            check("next_flag",   flag,        F_BLANK);
            check("next_winner", 32'(winner), 32'd0);
            check("next_busy",   32'(busy),   32'd1);
        end
    endtask

    task automatic model_reset();
        m_lives_a = LIVES;
        m_lives_b = LIVES;
        m_round   = 0;
        m_over    = 1'b0;
    endtask

    // Score a round from the game rules, then play it against the DUT.
    task automatic model_round(input logic [9:0] t, input logic [4:0] a, input logic [4:0] b,
                               input int enter_at, input int vdelay, input bit show_press);
        bit timed_out, hit_a, hit_b;
        logic [1:0] w;
        timed_out = (enter_at < 0);
        hit_a = !timed_out && (a == t[9:5]);
        hit_b = !timed_out && (b == t[4:0]);
        if (!hit_a && m_lives_a > 0) m_lives_a--;
        if (!hit_b && m_lives_b > 0) m_lives_b--;
        if (m_round < 255) m_round++;
        m_over = (m_lives_a == 0) || (m_lives_b == 0);
        if (!m_over)                             w = 2'b00;
        else if (m_lives_a == 0 && m_lives_b == 0) w = 2'b11;
        else if (m_lives_b == 0)                 w = 2'b01;
        else                                     w = 2'b10;
        play_round(t, a, b, enter_at, vdelay, show_press, (hit_a && hit_b) ? F_OK : F_BAD,
                   4'(m_lives_a), 4'(m_lives_b), 8'(m_round), m_over, w);
    endtask

    task automatic rand_round(input bit force_timeout, input bit all_correct);
        logic [9:0] t;
        logic [4:0] a, b;
        int ea;
        t = 10'($urandom_range(1, 1023));
        a = ($urandom_range(0, 99) < 65 || all_correct) ? t[9:5] : 5'($urandom);
        b = ($urandom_range(0, 99) < 65 || all_correct) ? t[4:0] : 5'($urandom);
        ea = int'($urandom_range(0, INPUT_C - 1));
        if (force_timeout || (!all_correct && $urandom_range(0, 99) < 15)) ea = -1;
        model_round(t, a, b, ea, int'($urandom_range(0, 3)), 1'($urandom));
    endtask

    initial begin
        vecs[0] = '{10'h2A6, 5'b10101, 5'b00110,  0, 1'b0, F_OK,  4'd3, 4'd3, 8'd1, 1'b0, 2'b00};
        vecs[1] = '{10'h15A, 5'b01010, 5'b00000,  3, 1'b0, F_BAD, 4'd3, 4'd2, 8'd2, 1'b0, 2'b00};
        vecs[2] = '{10'h3C1, 5'b11110, 5'b00001, -1, 1'b0, F_BAD, 4'd2, 4'd1, 8'd3, 1'b0, 2'b00};
        vecs[3] = '{10'h0F0, 5'b00111, 5'b10000,  9, 1'b0, F_OK,  4'd2, 4'd1, 8'd4, 1'b0, 2'b00};
        vecs[4] = '{10'h2A6, 5'b10101, 5'b11111,  5, 1'b1, F_BAD, 4'd2, 4'd0, 8'd5, 1'b1, 2'b01};
        vecs[5] = '{10'h1B3, 5'b01101, 5'b00000,  2, 1'b1, F_BAD, 4'd3, 4'd2, 8'd1, 1'b0, 2'b00};
        vecs[6] = '{10'h3FE, 5'b11111, 5'b11111,  0, 1'b1, F_BAD, 4'd3, 4'd1, 8'd2, 1'b0, 2'b00};
        vecs[7] = '{10'h001, 5'b00000, 5'b00011,  7, 1'b1, F_BAD, 4'd3, 4'd0, 8'd3, 1'b1, 2'b01};

        repeat (3) tick();
        rst = 1'b0;
        check("rst_led",    32'(led_out),  32'd0);
        check("rst_flag",   flag,          F_BLANK);
        check("rst_gen",    32'(gen_step), 32'd0);
        check("rst_seg_A",  32'(seg_A),    32'(LIVES));
        check("rst_seg_B",  32'(seg_B),    32'(LIVES));
        check("rst_round",  32'(round),    32'd0);
        check("rst_winner", 32'(winner),   32'd0);
        check("rst_busy",   32'(busy),     32'd0);

        // Constant table: two scripted games.
        start_game();
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
                end_game();
                start_game();
            end
            play_round(vecs[i].tgt, vecs[i].a, vecs[i].b, vecs[i].enter_at, i % 3,
                       vecs[i].show_press, vecs[i].flag, vecs[i].lives_a, vecs[i].lives_b,
                       vecs[i].rnd, vecs[i].over, vecs[i].win);
        end
        end_game();

        // Long all-correct game pushes the round counter into saturation, then a draw.
        start_game();
        model_reset();
        for (int r = 0; r < 256; r++) rand_round(1'b0, 1'b1);
        check("round_saturated", 32'(round), 32'd255);
        for (int r = 0; r < 3; r++) rand_round(1'b1, 1'b0);
        check("draw_winner", 32'(winner), 32'd3);
        end_game();

        // Random games against the reference model; forced timeouts guarantee an end.
        for (int g = 0; g < 3; g++) begin
            start_game();
            model_reset();
            for (int r = 0; r < 40 && !m_over; r++) rand_round(r >= 20, 1'b0);
            end_game();
        end

        // Reset in the middle of the show phase.
        start_game();
        model_reset();
        model_round(10'h2A6, 5'b10101, 5'b00000, 4, 0, 1'b0);
        tick();
        tgt = 10'h155;
        tgt_valid = 1'b1;
        tick();
        tgt_valid = 1'b0;
        check("led_before_rst", 32'(led_out), 32'h155);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_led",    32'(led_out),  32'd0);
        check("midrst_flag",   flag,          F_BLANK);
        check("midrst_seg_A",  32'(seg_A),    32'(LIVES));
        check("midrst_seg_B",  32'(seg_B),    32'(LIVES));
        check("midrst_round",  32'(round),    32'd0);
        check("midrst_busy",   32'(busy),     32'd0);
        check("midrst_gen",    32'(gen_step), 32'd0);
        check("midrst_winner", 32'(winner),   32'd0);
        repeat (3) tick();
        check("midrst_no_gen",  32'(gen_step), 32'd0);
        check("midrst_idle",    32'(busy),     32'd0);
        start_game();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Round sequencer for the two-player LED memory game.
- Requests a new 10-bit target pattern from the pattern generator datapath and shows it on the LED bar for a fixed time, then blanks it.
- Waits for the players to set their switches and press enter. Scores player A against target[9:5] and player B against target[4:0], and drives the result pattern to the 7-segment display.
- Tracks the lives of both players and ends the game when either player reaches zero lives.

Parameters:
- SHOW_CYCLES, 25000000, clock cycles the target stays on led_out.
- INPUT_CYCLES, 250000000, clock cycles allowed for the enter press; a timeout scores both players wrong.
- RESULT_CYCLES, 50000000, clock cycles the result pattern is held on flag.
- LIVES_INIT, 3, starting lives per player; must be between 1 and 15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enter  in  1  enter button, already synchronised to clk, active-high level.
- sw_A  in  5  player A guess.
- sw_B  in  5  player B guess.
- gen_step  out  1  one-cycle pulse requesting the next target from the datapath.
- tgt_valid  in  1  datapath strobe: tgt is valid this cycle.
- tgt  in  10  target pattern.
- led_out  out  10  LED bar.
- flag  out  32  7-segment pattern, active-low segments.
- seg_A  out  4  player A lives.
- seg_B  out  4  player B lives.
- round  out  8  completed-round count, saturates at 255.
- busy  out  1  high in every state except IDLE and OVER.
- winner  out  2  game result: 00 none, 01 A wins, 10 B wins, 11 draw.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE, led_out=0, flag=FLAG_BLANK, gen_step=0.
  - seg_A=seg_B=LIVES_INIT, round=0, winner=00, timer=0, edge detector cleared.
  - Reset overrides any state, including mid-round; no pending gen_step survives it.
- Enter edge: enter_rise = enter & ~enter_q, with enter_q registered. Only a rise is an event; a held button never re-triggers.
- IDLE: on enter_rise, go to ARM.
- ARM: gen_step=1 for exactly this cycle, then go to WAIT_TGT.
- WAIT_TGT:
  - Hold until tgt_valid. Capture tgt into tgt_r, load timer, go to SHOW.
  - tgt_valid outside WAIT_TGT is ignored.
- SHOW:
  - led_out=tgt_r. Timer counts down from SHOW_CYCLES-1; at 0, led_out=0, load timer, go to INPUT.
  - The show phase lasts exactly SHOW_CYCLES cycles.
  - enter_rise is ignored in this state.
- INPUT:
  - On enter_rise, register sw_A/sw_B into guess regs and go to CHECK.
  - Otherwise, when the timer reaches 0 after INPUT_CYCLES, set the timeout flag and go to CHECK.
  - If enter_rise and timer expiry fall on the same cycle, enter wins and the guesses are scored.
- CHECK (1 cycle):
  - ok_A = !timeout && guess_A==tgt_r[9:5]; ok_B = !timeout && guess_B==tgt_r[4:0].
  - Each wrong player loses one life, saturating at 0. Both players may lose in the same cycle.
  - flag = FLAG_CORRECT if ok_A && ok_B, else FLAG_WRONG.
  - round increments, saturating at 255. Go to RESULT.
- RESULT: hold flag for RESULT_CYCLES cycles, then:
  - if seg_A==0 || seg_B==0, go to OVER;
  - else flag=FLAG_BLANK and go to ARM (automatic next round).
- OVER:
  - winner is set on entry: 01 if only seg_B==0, 10 if only seg_A==0, 11 if both are 0.
  - flag stays FLAG_WRONG.
  - On enter_rise: go to IDLE, reload lives to LIVES_INIT, clear round and winner, flag=FLAG_BLANK.
- Timer width is 32 bits, unsigned; the constraint SHOW/INPUT/RESULT_CYCLES >= 1 is checked at elaboration.
- All outputs are registered. Latency from enter_rise in IDLE to gen_step is 2 cycles.

Decomposition:
- Package game_pkg holds:
  - state enum: IDLE, ARM, WAIT_TGT, SHOW, INPUT, CHECK, RESULT, OVER;
  - FLAG_CORRECT=32'hC2A3A3A1, FLAG_WRONG=32'hC7C0_9286, FLAG_BLANK=32'hFFFFFFFF;
  - winner encodings.
- One natural sub-module, phase_timer: loadable down-counter with a done pulse, shared by SHOW, INPUT and RESULT.

Test Plan (run with SHOW=4, INPUT=10, RESULT=3, LIVES=3):
- Reset, enter pulse, tgt=10'b1010100110 on tgt_valid -> gen_step at cycle 2, led_out=0x2A6 for exactly 4 cycles, then 0.
- INPUT with sw_A=5'b10101, sw_B=5'b00110, enter -> flag=C2A3A3A1 for 3 cycles, seg_A=seg_B=3, round=1, next gen_step issued.
- sw_A correct, sw_B wrong -> flag=C7C09286, seg_A=3, seg_B=2.
- No enter for 10 INPUT cycles -> timeout, both lives drop by 1; separately, enter on the expiry cycle scores normally.
- B wrong three rounds -> OVER, winner=01, busy=0; extra enter presses during SHOW have no effect; enter in OVER -> IDLE, lives=3, round=0.
- Assert rst during SHOW -> next cycle state IDLE, led_out=0, flag=FFFFFFFF, seg_A=seg_B=3.
